// File: rtl/word_assembler.sv
// Packs IN_W-bit beats into OUT_W-bit words with ready/valid on both sides and a
// one-word output holding register so assembly continues while a word waits.
module word_assembler #(
  parameter int IN_W      = 4,
  parameter int OUT_W     = 20,
  parameter bit MSB_FIRST = 1'b1,
  localparam int BEATS    = OUT_W / IN_W,
  localparam int CNT_W    = $clog2(BEATS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  input  logic             sync_clr,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] beat_cnt
);

  if (((OUT_W % IN_W) != 0) || ((OUT_W / IN_W) < 2)) begin : g_bad_params
    $error("word_assembler: OUT_W must be a multiple of IN_W with at least two beats");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  // Shifts one beat into a partial word following the selected beat order.
  function automatic logic [OUT_W-1:0] pack_beat(input logic [OUT_W-1:0] word,
                                                 input logic [IN_W-1:0]  beat);
    logic [OUT_W-1:0] res;
    if (MSB_FIRST) begin
      res = {word[OUT_W-IN_W-1:0], beat};
    end else begin
      res = {beat, word[OUT_W-1:IN_W]};
    end
    return res;
  endfunction

  logic [OUT_W-1:0] shift_r;
  logic [CNT_W-1:0] beat_cnt_r;
  logic [OUT_W-1:0] out_data_r;
  logic             out_valid_r;

  logic [OUT_W-1:0] shift_s;
  logic [CNT_W-1:0] beat_cnt_s;
  logic [OUT_W-1:0] out_data_s;
  logic             out_valid_s;
  logic [OUT_W-1:0] packed_s;
  logic             last_beat_s;
  logic             in_ready_s;
  logic             in_acc_s;
  logic             out_acc_s;
  logic             final_beat_s;

  // Handshake decode; a same-cycle output take frees the slot for the final beat.
  always_comb begin
    last_beat_s  = (beat_cnt_r == LAST_CNT);
    in_ready_s   = !(last_beat_s && out_valid_r && !out_ready);
    in_acc_s     = in_valid && in_ready_s;
    out_acc_s    = out_valid_r && out_ready;
    packed_s     = pack_beat(shift_r, in_data);
    final_beat_s = in_acc_s && last_beat_s && !sync_clr;
  end

  // Partial-word next state; a beat arriving with sync_clr starts a fresh word.
  always_comb begin
    shift_s    = shift_r;
    beat_cnt_s = beat_cnt_r;
    if (sync_clr) begin
      if (in_acc_s) begin
        shift_s    = pack_beat({OUT_W{1'b0}}, in_data);
        beat_cnt_s = ONE_CNT;
      end else begin
        shift_s    = {OUT_W{1'b0}};
        beat_cnt_s = {CNT_W{1'b0}};
      end
    end else if (final_beat_s) begin
      shift_s    = {OUT_W{1'b0}};
      beat_cnt_s = {CNT_W{1'b0}};
    end else if (in_acc_s) begin
      shift_s    = packed_s;
      beat_cnt_s = beat_cnt_r + ONE_CNT;
    end else begin
      shift_s    = shift_r;
      beat_cnt_s = beat_cnt_r;
    end
  end

  // Output holding register next state; a new word may replace one being taken.
  always_comb begin
    out_data_s  = out_data_r;
    out_valid_s = out_valid_r;
    if (final_beat_s) begin
      out_data_s  = packed_s;
      out_valid_s = 1'b1;
    end else if (out_acc_s) begin
      out_valid_s = 1'b0;
    end else begin
      out_valid_s = out_valid_r;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r     <= {OUT_W{1'b0}};
      beat_cnt_r  <= {CNT_W{1'b0}};
      out_data_r  <= {OUT_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      shift_r     <= shift_s;
      beat_cnt_r  <= beat_cnt_s;
      out_data_r  <= out_data_s;
      out_valid_r <= out_valid_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign beat_cnt  = beat_cnt_r;

  word_assembler_checker #(
    .OUT_W (OUT_W)
  ) u_checker (
    .clk       (clk),
    .rst_n     (rst_n),
    .out_valid (out_valid_r),
    .out_ready (out_ready),
    .out_data  (out_data_r)
  );

endmodule

// Watches the output side: a word offered but not taken must stay put.
module word_assembler_checker #(
  parameter int OUT_W = 20
) (
  input logic             clk,
  input logic             rst_n,
  input logic             out_valid,
  input logic             out_ready,
  input logic [OUT_W-1:0] out_data
);

  logic             held_r;
  logic [OUT_W-1:0] held_data_r;

  // Remembers the offered word and checks it survives a stalled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_r      <= 1'b0;
      held_data_r <= {OUT_W{1'b0}};
    end else begin
      if (held_r) begin
        assert (out_valid && (out_data == held_data_r))
          else $error("word_assembler: stalled output word changed");
      end
      held_r      <= out_valid && !out_ready;
      held_data_r <= out_data;
    end
  end

endmodule

// File: tb/tb_word_assembler.sv
// Scoreboard bench: default (4->20 MSB first), LSB-first and 8->32 instances.
module tb_word_assembler;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic a_in_valid, a_in_ready, a_sync_clr, a_out_valid, a_out_ready;
  logic [3:0]  a_in_data;
  logic [19:0] a_out_data;
  logic [2:0]  a_beat_cnt;

  logic b_in_valid, b_in_ready, b_sync_clr, b_out_valid, b_out_ready;
  logic [3:0]  b_in_data;
  logic [19:0] b_out_data;
  logic [2:0]  b_beat_cnt;

  logic c_in_valid, c_in_ready, c_sync_clr, c_out_valid, c_out_ready;
  logic [7:0]  c_in_data;
  logic [31:0] c_out_data;
  logic [1:0]  c_beat_cnt;

  int checks = 0;
  int failures = 0;
  logic [19:0] exp_a[$];
  logic [19:0] exp_b[$];
  logic [31:0] exp_c[$];

  word_assembler dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .sync_clr(a_sync_clr), .out_valid(a_out_valid),
    .out_data(a_out_data), .out_ready(a_out_ready), .beat_cnt(a_beat_cnt));

  word_assembler #(.IN_W(4), .OUT_W(20), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .sync_clr(b_sync_clr), .out_valid(b_out_valid),
    .out_data(b_out_data), .out_ready(b_out_ready), .beat_cnt(b_beat_cnt));

  word_assembler #(.IN_W(8), .OUT_W(32), .MSB_FIRST(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_data(c_in_data),
    .in_ready(c_in_ready), .sync_clr(c_sync_clr), .out_valid(c_out_valid),
    .out_data(c_out_data), .out_ready(c_out_ready), .beat_cnt(c_beat_cnt));

  // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
  task automatic drive_a(input logic v, input logic [3:0] d, input logic clr, input logic rdy);
    @(posedge clk); #1;
    a_in_valid = v; a_in_data = d; a_sync_clr = clr; a_out_ready = rdy;
    #1;
  endtask

  task automatic drive_b(input logic v, input logic [3:0] d, input logic rdy);
    @(posedge clk); #1;
    b_in_valid = v; b_in_data = d; b_sync_clr = 1'b0; b_out_ready = rdy;
    #1;
  endtask

  task automatic pop_a(input string name);
    logic [19:0] e;
    checks++;
    if (exp_a.size() == 0) begin
      failures++; $display("FAIL %s unexpected word got=%h", name, a_out_data);
    end else begin
      e = exp_a.pop_front();
      if (a_out_data !== e) begin
        failures++; $display("FAIL %s got=%h exp=%h", name, a_out_data, e);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = 4'h0; a_sync_clr = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = 4'h0; b_sync_clr = 1'b0; b_out_ready = 1'b0;
    c_in_valid = 1'b0; c_in_data = 8'h00; c_sync_clr = 1'b0; c_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_beat_cnt !== 3'd0) begin failures++; $display("FAIL reset_beat_cnt got=%0d exp=0", a_beat_cnt); end
    checks++; if (a_out_data !== 20'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", a_out_data); end
    checks++; if (c_out_valid !== 1'b0 || c_beat_cnt !== 2'd0) begin failures++; $display("FAIL reset_wide got=%b/%0d exp=0/0", c_out_valid, c_beat_cnt); end
    rst_n = 1'b1;
    @(posedge clk); #2;
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", a_in_ready); end
  endtask

  task automatic test_msb_first;
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b1, 4'(i + 1), 1'b0, 1'b1);
      checks++; if (a_beat_cnt !== 3'(i)) begin failures++; $display("FAIL msb_beat_cnt[%0d] got=%0d exp=%0d", i, a_beat_cnt, i); end
      checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL msb_early_valid[%0d] got=%b exp=0", i, a_out_valid); end
    end
    exp_a.push_back(20'h12345);
    drive_a(1'b0, 4'h0, 1'b0, 1'b1);
    checks++; if (a_out_valid !== 1'b1 || a_beat_cnt !== 3'd0) begin failures++; $display("FAIL msb_valid_rise got=%b/%0d exp=1/0", a_out_valid, a_beat_cnt); end
    if (a_out_valid === 1'b1) pop_a("msb_word");
    drive_a(1'b0, 4'h0, 1'b0, 1'b1);
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL msb_valid_pulse got=%b exp=0", a_out_valid); end
  endtask

  task automatic test_lsb_first;
    logic [19:0] e;
    for (int i = 0; i < 5; i++) drive_b(1'b1, 4'(i + 1), 1'b1);
    exp_b.push_back(20'h54321);
    drive_b(1'b0, 4'h0, 1'b1);
    checks++;
    if (b_out_valid !== 1'b1) begin
      failures++; $display("FAIL lsb_valid got=%b exp=1", b_out_valid);
    end else begin
      e = exp_b.pop_front();
      if (b_out_data !== e) begin failures++; $display("FAIL lsb_word got=%h exp=%h", b_out_data, e); end
    end
    drive_b(1'b0, 4'h0, 1'b1);
  endtask

  task automatic test_backpressure;
    for (int k = 1; k <= 9; k++) begin
      drive_a(1'b1, 4'(k), 1'b0, 1'b0);
      checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=1", k, a_in_ready); end
      if (k == 5) exp_a.push_back(20'h12345);
      if (k >= 6) begin
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== 20'h12345) begin failures++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/12345", k, a_out_valid, a_out_data); end
      end
    end
    for (int s = 0; s < 2; s++) begin
      drive_a(1'b1, 4'hA, 1'b0, 1'b0);
      checks++; if (a_in_ready !== 1'b0 || a_beat_cnt !== 3'd4) begin failures++; $display("FAIL bp_stall[%0d] got=%b/%0d exp=0/4", s, a_in_ready, a_beat_cnt); end
      checks++; if (a_out_valid !== 1'b1 || a_out_data !== exp_a[0]) begin failures++; $display("FAIL bp_stable[%0d] got=%b/%h exp=1/%h", s, a_out_valid, a_out_data, exp_a[0]); end
    end
    drive_a(1'b1, 4'hA, 1'b0, 1'b1);
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%b exp=1", a_in_ready); end
    exp_a.push_back(20'h6789A);
    pop_a("bp_first_word");
    drive_a(1'b0, 4'h0, 1'b0, 1'b0);
    checks++; if (a_out_valid !== 1'b1 || a_out_data !== exp_a[0] || a_beat_cnt !== 3'd0) begin failures++; $display("FAIL bp_zero_bubble got=%b/%h/%0d exp=1/%h/0", a_out_valid, a_out_data, a_beat_cnt, exp_a[0]); end
    drive_a(1'b0, 4'h0, 1'b0, 1'b1);
    pop_a("bp_second_word");
    drive_a(1'b0, 4'h0, 1'b0, 1'b1);
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", a_out_valid); end
  endtask

  task automatic test_sync_clr;
    drive_a(1'b1, 4'h7, 1'b0, 1'b1);
    drive_a(1'b0, 4'h0, 1'b1, 1'b1);
    drive_a(1'b0, 4'h0, 1'b0, 1'b1);
    checks++; if (a_beat_cnt !== 3'd0) begin failures++; $display("FAIL clr_alone got=%0d exp=0", a_beat_cnt); end
    drive_a(1'b1, 4'hF, 1'b0, 1'b1);
    drive_a(1'b1, 4'hE, 1'b0, 1'b1);
    drive_a(1'b1, 4'h1, 1'b1, 1'b1);
    checks++; if (a_in_ready !== 1'b1 || a_beat_cnt !== 3'd2) begin failures++; $display("FAIL clr_pre got=%b/%0d exp=1/2", a_in_ready, a_beat_cnt); end
    for (int k = 2; k <= 5; k++) begin
      drive_a(1'b1, 4'(k), 1'b0, 1'b1);
      checks++; if (a_beat_cnt !== 3'(k - 1) || a_out_valid !== 1'b0) begin failures++; $display("FAIL clr_cnt[%0d] got=%0d/%b exp=%0d/0", k, a_beat_cnt, a_out_valid, k - 1); end
    end
    exp_a.push_back(20'h12345);
    drive_a(1'b0, 4'h0, 1'b0, 1'b1);
    checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL clr_valid got=%b exp=1", a_out_valid); end
    if (a_out_valid === 1'b1) pop_a("clr_word");
    drive_a(1'b0, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset;
    for (int k = 1; k <= 8; k++) drive_a(1'b1, 4'(k), 1'b0, 1'b0);
    drive_a(1'b0, 4'h0, 1'b0, 1'b0);
    checks++; if (a_beat_cnt !== 3'd3 || a_out_valid !== 1'b1) begin failures++; $display("FAIL arst_pre got=%0d/%b exp=3/1", a_beat_cnt, a_out_valid); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_beat_cnt !== 3'd0 || a_out_data !== 20'h0) begin failures++; $display("FAIL arst_immediate got=%b/%0d/%h exp=0/0/0", a_out_valid, a_beat_cnt, a_out_data); end
    #2 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive_a(1'b1, 4'(4'hA + k), 1'b0, 1'b1);
      checks++; if (a_beat_cnt !== 3'(k) || a_out_valid !== 1'b0) begin failures++; $display("FAIL arst_cnt[%0d] got=%0d/%b exp=%0d/0", k, a_beat_cnt, a_out_valid, k); end
    end
    exp_a.push_back(20'hABCDE);
    drive_a(1'b0, 4'h0, 1'b0, 1'b1);
    checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL arst_valid got=%b exp=1", a_out_valid); end
    if (a_out_valid === 1'b1) pop_a("arst_word");
    drive_a(1'b0, 4'h0, 1'b0, 1'b1);
    checks++; if (exp_a.size() != 0) begin failures++; $display("FAIL a_leftover got=%0d exp=0", exp_a.size()); end
  endtask

  task automatic test_random_wide;
    int sent = 0;
    int beat_idx = 0;
    int recv = 0;
    int cycles = 0;
    logic [31:0] acc = 32'h0;
    logic [31:0] e;
    logic held = 1'b0;
    logic [31:0] held_data = 32'h0;
    while (recv < 1000 && cycles < 60000) begin
      @(posedge clk); #1;
      c_in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      c_in_data   = 8'($urandom);
      c_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (held) begin
        checks++;
        if (c_out_valid !== 1'b1 || c_out_data !== held_data) begin failures++; $display("FAIL rnd_hold got=%b/%h exp=1/%h", c_out_valid, c_out_data, held_data); end
      end
      if (c_in_valid && c_in_ready) begin
        acc = {acc[23:0], c_in_data};
        beat_idx++;
        if (beat_idx == 4) begin
          exp_c.push_back(acc);
          beat_idx = 0;
          sent++;
        end
      end
      if (c_out_valid === 1'b1 && c_out_ready) begin
        checks++;
        if (exp_c.size() == 0) begin
          failures++; $display("FAIL rnd_extra_word got=%h", c_out_data);
        end else begin
          e = exp_c.pop_front();
          if (c_out_data !== e) begin failures++; $display("FAIL rnd_word[%0d] got=%h exp=%h", recv, c_out_data, e); end
        end
        recv++;
      end
      held = (c_out_valid === 1'b1) && !c_out_ready;
      held_data = c_out_data;
      cycles++;
    end
    c_in_valid = 1'b0; c_out_ready = 1'b0;
    checks++; if (recv != 1000) begin failures++; $display("FAIL rnd_count got=%0d exp=1000", recv); end
    checks++; if (exp_c.size() != 0) begin failures++; $display("FAIL rnd_leftover got=%0d exp=0", exp_c.size()); end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_backpressure();
    test_sync_clr();
    test_async_reset();
    test_random_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
